// File: rtl/tdm_demux_if.sv
// Serial TDM receive bus: framed bitstream in, per-channel word slots and strobes out.
interface tdm_demux_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic                      din;
  logic                      din_valid;
  logic                      frame_sync;
  logic [CHANNELS*WIDTH-1:0] ch_data;
  logic [CHANNELS-1:0]       ch_valid;
  logic                      frame_done;
  logic                      sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  ch_data, ch_valid, frame_done, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output ch_data, ch_valid, frame_done, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// Serial time-division demultiplexer: assembles MSB-first words from a framed bitstream
// and routes each completed word to its channel slot with a one-cycle strobe.
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(CHANNELS);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);

  typedef enum logic [0:0] {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t                    r_state;
  logic [BW-1:0]             r_bit_cnt;
  logic [CW-1:0]             r_ch_cnt;
  logic [WIDTH-1:0]          r_shift;
  logic [CHANNELS*WIDTH-1:0] r_ch_data;
  logic [CHANNELS-1:0]       r_ch_valid;
  logic                      r_frame_done;
  logic                      r_sync_err;

  logic [WIDTH-1:0]          w_word;
  logic                      w_at_start;

  assign w_word     = {r_shift[WIDTH-2:0], bus.din};
  assign w_at_start = (r_bit_cnt == {BW{1'b0}}) && (r_ch_cnt == {CW{1'b0}});

  // Framing FSM, word assembly and registered slot/strobe outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_bit_cnt    <= {BW{1'b0}};
      r_ch_cnt     <= {CW{1'b0}};
      r_shift      <= {WIDTH{1'b0}};
      r_ch_data    <= {(CHANNELS*WIDTH){1'b0}};
      r_ch_valid   <= {CHANNELS{1'b0}};
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_ch_valid   <= {CHANNELS{1'b0}};
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      if (bus.din_valid) begin
        case (r_state)
          HUNT: begin
            if (bus.frame_sync) begin
              r_state   <= RUN;
              r_shift   <= {{(WIDTH-1){1'b0}}, bus.din};
              r_bit_cnt <= {{(BW-1){1'b0}}, 1'b1};
              r_ch_cnt  <= {CW{1'b0}};
            end
          end
          RUN: begin
            if (w_at_start && !bus.frame_sync) begin
              // Missing sync where a frame must begin: drop lock and hunt again
              r_sync_err <= 1'b1;
              r_state    <= HUNT;
            end else if (!w_at_start && bus.frame_sync) begin
              // Unexpected sync: abandon partial frame, this beat is the new ch0 MSB
              r_sync_err <= 1'b1;
              r_shift    <= {{(WIDTH-1){1'b0}}, bus.din};
              r_bit_cnt  <= {{(BW-1){1'b0}}, 1'b1};
              r_ch_cnt   <= {CW{1'b0}};
            end else if (r_bit_cnt == LAST_BIT) begin
              for (int k = 0; k < CHANNELS; k++) begin
                if (r_ch_cnt == CW'(k)) begin
                  r_ch_data[k*WIDTH +: WIDTH] <= w_word;
                  r_ch_valid[k]               <= 1'b1;
                end
              end
              r_shift   <= w_word;
              r_bit_cnt <= {BW{1'b0}};
              if (r_ch_cnt == LAST_CH) begin
                r_frame_done <= 1'b1;
                r_ch_cnt     <= {CW{1'b0}};
              end else begin
                r_ch_cnt <= r_ch_cnt + CW'(1);
              end
            end else begin
              r_shift   <= w_word;
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign bus.ch_data    = r_ch_data;
  assign bus.ch_valid   = r_ch_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.sync_err   = r_sync_err;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed, table-driven bench for tdm_demux (CHANNELS=4, WIDTH=8).
module tb_tdm_demux;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tdm_demux_if #(.CHANNELS(4), .WIDTH(8)) bus ();

  tdm_demux #(.CHANNELS(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  word;
    logic        sync;
    int          gap;
    logic [3:0]  exp_valid;
    logic        exp_fd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic beat(input logic d, input logic s);
    @(negedge clk);
    bus.din        = d;
    bus.frame_sync = s;
    bus.din_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
  endtask

  task automatic idle(input int n, input string name);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      chk({name, " gap ch_valid"}, {28'd0, bus.ch_valid}, 32'd0);
      chk({name, " gap frame_done"}, {31'd0, bus.frame_done}, 32'd0);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic sync, input int gap,
                           input logic [3:0] exp_valid, input logic exp_fd,
                           input logic exp_serr_first, input logic [31:0] exp_data,
                           input string name);
    for (int i = 0; i < 8; i++) begin
      beat(w[7-i], (i == 0) ? sync : 1'b0);
      chk({name, " sync_err"}, {31'd0, bus.sync_err},
          {31'd0, (i == 0) ? exp_serr_first : 1'b0});
      if (i < 7) begin
        chk({name, " early ch_valid"}, {28'd0, bus.ch_valid}, 32'd0);
        chk({name, " early frame_done"}, {31'd0, bus.frame_done}, 32'd0);
      end else begin
        chk({name, " ch_valid"}, {28'd0, bus.ch_valid}, {28'd0, exp_valid});
        chk({name, " frame_done"}, {31'd0, bus.frame_done}, {31'd0, exp_fd});
        chk({name, " ch_data"}, bus.ch_data, exp_data);
      end
      if (gap > 0) idle(gap, name);
    end
  endtask

  task automatic quiet_beats(input int n, input logic [31:0] exp_data, input string name);
    for (int i = 0; i < n; i++) begin
      beat(i[0], 1'b0);
      chk({name, " ch_valid"}, {28'd0, bus.ch_valid}, 32'd0);
      chk({name, " sync_err"}, {31'd0, bus.sync_err}, 32'd0);
      chk({name, " ch_data"}, bus.ch_data, exp_data);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.din        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    rst_n          = 1'b0;

    // T2: single frame; T3: same frame with idle gaps; T4: back-to-back frame
    vecs[0]  = '{8'hA5, 1'b1, 0, 4'b0001, 1'b0, 32'h000000A5};
    vecs[1]  = '{8'h3C, 1'b0, 0, 4'b0010, 1'b0, 32'h00003CA5};
    vecs[2]  = '{8'hFF, 1'b0, 0, 4'b0100, 1'b0, 32'h00FF3CA5};
    vecs[3]  = '{8'h01, 1'b0, 0, 4'b1000, 1'b1, 32'h01FF3CA5};
    vecs[4]  = '{8'hA5, 1'b1, 2, 4'b0001, 1'b0, 32'h01FF3CA5};
    vecs[5]  = '{8'h3C, 1'b0, 2, 4'b0010, 1'b0, 32'h01FF3CA5};
    vecs[6]  = '{8'hFF, 1'b0, 1, 4'b0100, 1'b0, 32'h01FF3CA5};
    vecs[7]  = '{8'h01, 1'b0, 0, 4'b1000, 1'b1, 32'h01FF3CA5};
    vecs[8]  = '{8'h11, 1'b1, 0, 4'b0001, 1'b0, 32'h01FF3C11};
    vecs[9]  = '{8'h22, 1'b0, 0, 4'b0010, 1'b0, 32'h01FF2211};
    vecs[10] = '{8'h33, 1'b0, 0, 4'b0100, 1'b0, 32'h01332211};
    vecs[11] = '{8'h44, 1'b0, 0, 4'b1000, 1'b1, 32'h44332211};

    repeat (3) @(posedge clk);
    #1;
    chk("reset ch_data", bus.ch_data, 32'd0);
    chk("reset ch_valid", {28'd0, bus.ch_valid}, 32'd0);
    chk("reset flags", {30'd0, bus.frame_done, bus.sync_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 12; v++) begin
      send_word(vecs[v].word, vecs[v].sync, vecs[v].gap, vecs[v].exp_valid,
                vecs[v].exp_fd, 1'b0, vecs[v].exp_data, $sformatf("vec%0d", v));
    end

    // T1: asynchronous reset in the middle of a frame
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset ch_data", bus.ch_data, 32'd0);
    chk("midreset ch_valid", {28'd0, bus.ch_valid}, 32'd0);
    chk("midreset flags", {30'd0, bus.frame_done, bus.sync_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_beats(10, 32'd0, "hunt_after_reset");

    // T5: unexpected sync on beat 12 (inside ch1)
    send_word(8'h5A, 1'b1, 0, 4'b0001, 1'b0, 1'b0, 32'h0000005A, "t5_ch0");
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 1'b0);
      chk("t5 partial ch_valid", {28'd0, bus.ch_valid}, 32'd0);
      chk("t5 partial sync_err", {31'd0, bus.sync_err}, 32'd0);
    end
    send_word(8'h81, 1'b1, 0, 4'b0001, 1'b0, 1'b1, 32'h00000081, "t5_resync_ch0");
    send_word(8'h42, 1'b0, 0, 4'b0010, 1'b0, 1'b0, 32'h00004281, "t5_ch1");
    send_word(8'h24, 1'b0, 0, 4'b0100, 1'b0, 1'b0, 32'h00244281, "t5_ch2");
    send_word(8'h18, 1'b0, 0, 4'b1000, 1'b1, 1'b0, 32'h18244281, "t5_ch3");

    // T6: beat 33 without sync -> error and hunt; unsynced beats ignored
    beat(1'b1, 1'b0);
    chk("t6 sync_err", {31'd0, bus.sync_err}, 32'd1);
    chk("t6 ch_valid", {28'd0, bus.ch_valid}, 32'd0);
    quiet_beats(8, 32'h18244281, "t6_hunt");
    send_word(8'hEF, 1'b1, 0, 4'b0001, 1'b0, 1'b0, 32'h182442EF, "t6_ch0");
    send_word(8'hBE, 1'b0, 0, 4'b0010, 1'b0, 1'b0, 32'h1824BEEF, "t6_ch1");
    send_word(8'hAD, 1'b0, 0, 4'b0100, 1'b0, 1'b0, 32'h18ADBEEF, "t6_ch2");
    send_word(8'hDE, 1'b0, 0, 4'b1000, 1'b1, 1'b0, 32'hDEADBEEF, "t6_ch3");
    idle(2, "tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
